// File: rtl/conv_stream_loader_if.sv
// Stream, buffer and status bundle for conv_stream_loader.
// The master modport is the loader side and the slave modport is the DDR/buffer environment side.
`timescale 1ns/1ps
interface conv_stream_loader_if #(
    parameter int DATA_WIDTH = 64,
    parameter int B_PARA     = 64
);
    logic                  start;
    logic [DATA_WIDTH-1:0] s_tdata;
    logic                  s_tvalid;
    logic                  s_tlast;
    logic                  s_tready;
    logic                  fb_full;
    logic                  wb_full;
    logic [B_PARA-1:0]     para;
    logic                  para_we;
    logic                  wb_we;
    logic                  wb_clr;
    logic                  fb_we;
    logic                  fb_clr;
    logic [DATA_WIDTH-1:0] dout;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        input  start, s_tdata, s_tvalid, s_tlast, fb_full, wb_full,
        output s_tready, para, para_we, wb_we, wb_clr, fb_we, fb_clr, dout, busy, done, err
    );

    modport slave (
        output start, s_tdata, s_tvalid, s_tlast, fb_full, wb_full,
        input  s_tready, para, para_we, wb_we, wb_clr, fb_we, fb_clr, dout, busy, done, err
    );
endinterface

// File: rtl/conv_stream_loader.sv
// Layer loader: clears the buffers, takes a parameter word and a count word, then streams weights and features.
// Optional tlast framing check enabled by defining CONV_STREAM_LOADER_TLAST_CHK_EN.
`timescale 1ns/1ps
module conv_stream_loader #(
    parameter int DATA_WIDTH = 64,
    parameter int B_PARA     = 64,
    parameter int B_CNT      = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    conv_stream_loader_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        HDR_PARA,
        HDR_CNT,
        WEI,
        FTM,
        FIN
    } state_t;

    state_t                r_state;
    logic [B_PARA-1:0]     r_para;
    logic                  r_para_we;
    logic                  r_wb_we;
    logic                  r_fb_we;
    logic                  r_clr;
    logic                  r_busy;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_dout;
    logic [B_CNT-1:0]      r_wei_cnt;
    logic [B_CNT-1:0]      r_ftm_cnt;

    logic                  w_ready;
    logic                  w_accept;
    logic [B_CNT-1:0]      w_hdr_wei;
    logic [B_CNT-1:0]      w_hdr_ftm;

    // Ready is a pure decode of the state and the buffer full flags, held low throughout reset.
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            HDR_PARA: w_ready = 1'b1;
            HDR_CNT:  w_ready = 1'b1;
            WEI:      w_ready = !bus.wb_full;
            FTM:      w_ready = !bus.fb_full;
            default:  w_ready = 1'b0;
        endcase
        if (!rstn) begin
            w_ready = 1'b0;
        end
    end

    assign w_accept  = bus.s_tvalid && w_ready;
    assign w_hdr_wei = bus.s_tdata[B_CNT-1:0];
    assign w_hdr_ftm = bus.s_tdata[32+B_CNT-1:32];

    // A count of zero skips its section entirely, so the header decides the first data section.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_para    <= '0;
            r_para_we <= 1'b0;
            r_wb_we   <= 1'b0;
            r_fb_we   <= 1'b0;
            r_clr     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dout    <= '0;
            r_wei_cnt <= '0;
            r_ftm_cnt <= '0;
        end else begin
            r_para_we <= 1'b0;
            r_wb_we   <= 1'b0;
            r_fb_we   <= 1'b0;
            r_clr     <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= CLR;
                        r_clr   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                CLR: begin
                    r_state <= HDR_PARA;
                end
                HDR_PARA: begin
                    if (w_accept) begin
                        r_para    <= bus.s_tdata[B_PARA-1:0];
                        r_para_we <= 1'b1;
                        r_state   <= HDR_CNT;
                    end
                end
                HDR_CNT: begin
                    if (w_accept) begin
                        r_wei_cnt <= w_hdr_wei;
                        r_ftm_cnt <= w_hdr_ftm;
                        if (w_hdr_wei != '0) begin
                            r_state <= WEI;
                        end else if (w_hdr_ftm != '0) begin
                            r_state <= FTM;
                        end else begin
                            r_state <= FIN;
                            r_done  <= 1'b1;
                        end
                    end
                end
                WEI: begin
                    if (w_accept) begin
                        r_dout    <= bus.s_tdata;
                        r_wb_we   <= 1'b1;
                        r_wei_cnt <= r_wei_cnt - B_CNT'(1);
                        if (r_wei_cnt == B_CNT'(1)) begin
                            if (r_ftm_cnt != '0) begin
                                r_state <= FTM;
                            end else begin
                                r_state <= FIN;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                end
                FTM: begin
                    if (w_accept) begin
                        r_dout    <= bus.s_tdata;
                        r_fb_we   <= 1'b1;
                        r_ftm_cnt <= r_ftm_cnt - B_CNT'(1);
                        if (r_ftm_cnt == B_CNT'(1)) begin
                            r_state <= FIN;
                            r_done  <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CONV_STREAM_LOADER_TLAST_CHK_EN
    logic w_last_beat;
    logic r_err;

    // The final beat is the last feature word, the last weight word when there are no features,
    // or the count word itself when both sections are empty.
    always_comb begin
        w_last_beat = 1'b0;
        case (r_state)
            HDR_CNT: w_last_beat = (w_hdr_wei == '0) && (w_hdr_ftm == '0);
            WEI:     w_last_beat = (r_wei_cnt == B_CNT'(1)) && (r_ftm_cnt == '0);
            FTM:     w_last_beat = (r_ftm_cnt == B_CNT'(1));
            default: w_last_beat = 1'b0;
        endcase
    end

    // Sticky framing error; loading carries on regardless and only a new start or reset clears it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_err <= 1'b0;
        end else if (r_state == IDLE && bus.start) begin
            r_err <= 1'b0;
        end else if (w_accept && (bus.s_tlast != w_last_beat)) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.s_tready = w_ready;
    assign bus.para     = r_para;
    assign bus.para_we  = r_para_we;
    assign bus.wb_we    = r_wb_we;
    assign bus.fb_we    = r_fb_we;
    assign bus.wb_clr   = r_clr;
    assign bus.fb_clr   = r_clr;
    assign bus.dout     = r_dout;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule
